// File: rtl/obc_dft_bin_mac.sv
// OBC distributed-arithmetic engine: one DFT bin component over 2*PAIRS samples, bit-serial LSB first.
// Optional OBC_OUT_SAT_EN clamps the result to the signed OUT_W range instead of wrapping.
module obc_dft_bin_mac #(
    parameter int PAIRS  = 8,
    parameter int DATA_W = 16,
    parameter int COEF_W = 32,
    parameter int OUT_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       coef_we,
    input  logic [$clog2(PAIRS):0]     coef_addr,
    input  logic [COEF_W-1:0]          coef_wdata,
    input  logic                       off_we,
    input  logic [COEF_W-1:0]          off_wdata,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2*PAIRS*DATA_W-1:0]  in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           out_data,
    output logic                       sat_flag,
    output logic                       busy
);

    localparam int ACC_W = COEF_W + DATA_W + $clog2(PAIRS) + 1;
    localparam int AW    = $clog2(PAIRS) + 1;
    localparam int NS    = 2 * PAIRS;
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [COEF_W-1:0]   coef_q [NS];
    logic [COEF_W-1:0]   coef_d [NS];
    logic [COEF_W-1:0]   off_q, off_d;
    logic [DATA_W-1:0]   smp_q [NS];
    logic [DATA_W-1:0]   smp_d [NS];
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [OUT_W-1:0]    out_data_q, out_data_d;
    logic                sat_q, sat_d;
    logic                out_valid_q, out_valid_d;

    logic [ACC_W-1:0]    p_sum;
    logic [ACC_W-1:0]    p_shift;
    logic [ACC_W-1:0]    acc_run;
    logic [AW-1:0]       p_idx;
    logic                last_bit;
    logic [OUT_W-1:0]    res_data;
    logic                res_sat;

    // Partial product for the current bit plane: each pair picks C[k][x_2k ^ x_2k+1].
    always_comb begin
        p_sum = '0;
        p_idx = '0;
        for (int unsigned k = 0; k < PAIRS; k++) begin
            p_idx = {k[AW-2:0], smp_q[2*k][0] ^ smp_q[2*k+1][0]};
            p_sum = p_sum + ACC_W'($signed(coef_q[p_idx]));
        end
    end

    always_comb begin
        last_bit = (cnt_q == CNT_W'(DATA_W - 1));
        p_shift  = p_sum << cnt_q;
        acc_run  = last_bit ? (acc_q - p_shift) : (acc_q + p_shift);
    end

`ifdef OBC_OUT_SAT_EN
    always_comb begin
        res_data = acc_run[OUT_W-1:0];
        res_sat  = 1'b0;
        if (!((&acc_run[ACC_W-1:OUT_W-1]) || !(|acc_run[ACC_W-1:OUT_W-1]))) begin
            res_sat  = 1'b1;
            res_data = acc_run[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                        : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end
`else
    logic acc_hi_unused;
    always_comb begin
        res_data      = acc_run[OUT_W-1:0];
        res_sat       = 1'b0;
        acc_hi_unused = ^acc_run[ACC_W-1:OUT_W];
    end
`endif

    always_comb begin
        state_d     = state_q;
        coef_d      = coef_q;
        off_d       = off_q;
        smp_d       = smp_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        sat_d       = sat_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE: begin
                if (coef_we) coef_d[coef_addr] = coef_wdata;
                if (off_we)  off_d = off_wdata;
                if (in_valid) begin
                    // off_d already carries a same-cycle offset write.
                    for (int unsigned i = 0; i < NS; i++)
                        smp_d[i] = in_data[i*DATA_W +: DATA_W];
                    acc_d   = ACC_W'($signed(off_d));
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                for (int unsigned i = 0; i < NS; i++)
                    smp_d[i] = smp_q[i] >> 1;
                acc_d = acc_run;
                cnt_d = cnt_q + 1'b1;
                if (last_bit) begin
                    out_data_d  = res_data;
                    sat_d       = res_sat;
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            off_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            for (int unsigned i = 0; i < NS; i++) begin
                coef_q[i] <= '0;
                smp_q[i]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            coef_q      <= coef_d;
            off_q       <= off_d;
            smp_q       <= smp_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_obc_dft_bin_mac.sv
// Directed self-checking bench for obc_dft_bin_mac at default parameters.
// Expected values are hand-derived; OBC_OUT_SAT_EN selects the saturation expectations.
module tb_obc_dft_bin_mac;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         coef_we = 1'b0;
    logic [3:0]   coef_addr = '0;
    logic [31:0]  coef_wdata = '0;
    logic         off_we = 1'b0;
    logic [31:0]  off_wdata = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [255:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [31:0]  out_data;
    logic         sat_flag;
    logic         busy;

    int tests = 0;
    int fails = 0;

    obc_dft_bin_mac #(.PAIRS(8), .DATA_W(16), .COEF_W(32), .OUT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .off_we(off_we), .off_wdata(off_wdata),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .sat_flag(sat_flag), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick; tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic wr_coef(input logic [3:0] a, input logic [31:0] v);
        coef_we = 1'b1; coef_addr = a; coef_wdata = v;
        tick;
        coef_we = 1'b0;
    endtask

    task automatic wr_off(input logic [31:0] v);
        off_we = 1'b1; off_wdata = v;
        tick;
        off_we = 1'b0;
    endtask

    task automatic start_job(input logic [255:0] d);
        in_valid = 1'b1; in_data = d;
        tick;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick;
            lat++;
        end
    endtask

    task automatic finish_job;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tests++; if (out_data !== 32'h0) begin fails++; $display("FAIL reset_out_data got %h want 0", out_data); end
        tests++; if (sat_flag !== 1'b0) begin fails++; $display("FAIL reset_sat got %b want 0", sat_flag); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_offset_latency;
        int lat;
        do_reset;
        wr_off(32'd5);
        start_job(256'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_0F0F_F0F0_AAAA_5555_1357_9BDF_2468_ACE0);
        tests++; if (busy !== 1'b1 || in_ready !== 1'b0) begin fails++; $display("FAIL run_flags got busy=%b in_ready=%b want 1/0", busy, in_ready); end
        wait_valid(lat);
        tests++; if (lat != 16) begin fails++; $display("FAIL latency got %0d want 16", lat); end
        tests++; if (out_data !== 32'd5) begin fails++; $display("FAIL offset_only got %h want 00000005", out_data); end
        tests++; if (sat_flag !== 1'b0) begin fails++; $display("FAIL offset_sat got %b want 0", sat_flag); end
        finish_job;
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL done_exit got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
    endtask

    task automatic test_lsb_msb;
        int lat;
        logic [255:0] d;
        do_reset;
        wr_coef(4'd1, 32'd1);
        d = '0; d[15:0] = 16'h0001;
        start_job(d);
        wait_valid(lat);
        tests++; if (out_data !== 32'h0000_0001) begin fails++; $display("FAIL lsb_only got %h want 00000001", out_data); end
        finish_job;
        d = '0; d[15:0] = 16'h8000;
        start_job(d);
        wait_valid(lat);
        tests++; if (out_data !== 32'hFFFF_8000) begin fails++; $display("FAIL msb_only got %h want ffff8000", out_data); end
        finish_job;
    endtask

    task automatic test_negative;
        int lat;
        logic [255:0] d;
        do_reset;
        wr_coef(4'd0, 32'd3);
        d = '0; d[31:0] = 32'hFFFF_FFFF;
        start_job(d);
        wait_valid(lat);
        tests++; if (out_data !== 32'hFFFF_FFFD) begin fails++; $display("FAIL both_ones got %h want fffffffd", out_data); end
        finish_job;
    endtask

    task automatic test_same_cycle_write;
        int lat;
        logic [255:0] d;
        do_reset;
        d = '0; d[15:0] = 16'h0001;
        off_we = 1'b1; off_wdata = 32'd9;
        coef_we = 1'b1; coef_addr = 4'd1; coef_wdata = 32'd2;
        start_job(d);
        off_we = 1'b0; coef_we = 1'b0;
        wait_valid(lat);
        tests++; if (out_data !== 32'd11) begin fails++; $display("FAIL same_cycle_write got %h want 0000000b", out_data); end
        finish_job;
    endtask

    task automatic test_hold_done;
        int lat;
        logic [255:0] d;
        do_reset;
        wr_coef(4'd1, 32'd1);
        d = '0; d[15:0] = 16'h0001;
        start_job(d);
        wait_valid(lat);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0]; in_data = '0;
            coef_we = 1'b1; coef_addr = 4'd0; coef_wdata = 32'h55;
            off_we = 1'b1; off_wdata = 32'd100;
            tick;
            tests++; if (out_data !== 32'd1 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                fails++; $display("FAIL hold_done[%0d] got data=%h valid=%b in_ready=%b want 00000001/1/0", i, out_data, out_valid, in_ready);
            end
        end
        in_valid = 1'b0; coef_we = 1'b0; off_we = 1'b0;
        finish_job;
        tests++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            fails++; $display("FAIL hold_release got in_ready=%b busy=%b valid=%b want 1/0/0", in_ready, busy, out_valid);
        end
        start_job('0);
        wait_valid(lat);
        tests++; if (out_data !== 32'd0) begin fails++; $display("FAIL table_unchanged got %h want 00000000", out_data); end
        finish_job;
    endtask

    task automatic test_reset_abort;
        int lat;
        int seen;
        do_reset;
        wr_off(32'd7);
        wr_coef(4'd0, 32'd1);
        start_job('0);
        repeat (5) tick;
        rst_n = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL abort_state got valid=%b in_ready=%b busy=%b want 0/1/0", out_valid, in_ready, busy);
        end
        tick;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (out_valid) seen++;
        end
        tests++; if (seen != 0) begin fails++; $display("FAIL abort_no_result got %0d valid cycles want 0", seen); end
        start_job('0);
        wait_valid(lat);
        tests++; if (out_data !== 32'd0) begin fails++; $display("FAIL abort_table_cleared got %h want 00000000", out_data); end
        finish_job;
    endtask

    task automatic test_back_to_back;
        int first;
        int second;
        int n;
        do_reset;
        first = -1; second = -1; n = 0;
        out_ready = 1'b1; in_valid = 1'b1; in_data = '0;
        while (second < 0 && n < 100) begin
            tick;
            n++;
            if (out_valid) begin
                if (first < 0) first = n;
                else second = n;
            end
        end
        out_ready = 1'b0; in_valid = 1'b0;
        tests++; if (second - first != 18 || first < 0) begin
            fails++; $display("FAIL initiation_interval got %0d want 18", second - first);
        end
        tick; tick;
    endtask

    task automatic test_sat;
        int lat;
        do_reset;
        wr_off(32'd0);
        for (int i = 0; i < 16; i++) wr_coef(4'(i), 32'h7FFF_FFFF);
        start_job('0);
        wait_valid(lat);
`ifdef OBC_OUT_SAT_EN
        tests++; if (out_data !== 32'h8000_0000) begin fails++; $display("FAIL sat_data got %h want 80000000", out_data); end
        tests++; if (sat_flag !== 1'b1) begin fails++; $display("FAIL sat_flag got %b want 1", sat_flag); end
`else
        tests++; if (out_data !== 32'h0000_0008) begin fails++; $display("FAIL wrap_data got %h want 00000008", out_data); end
        tests++; if (sat_flag !== 1'b0) begin fails++; $display("FAIL wrap_flag got %b want 0", sat_flag); end
`endif
        finish_job;
    endtask

    initial begin
        tick;
        test_reset;
        test_offset_latency;
        test_lsb_msb;
        test_negative;
        test_same_cycle_write;
        test_hold_done;
        test_reset_abort;
        test_back_to_back;
        test_sat;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/obc_dft_bin_mac.md
Name: obc_dft_bin_mac

Overview:
Parametrised OBC distributed-arithmetic engine that computes one DFT bin component (real or imaginary) over 2*PAIRS input samples.
- Successor to the fixed per-bin coefficient ROMs. The two-entry-per-pair coefficient table is runtime-writable, so one block serves any bin and either component.
- Input samples are processed bit-serially, LSB first, with shift-accumulate into a wide accumulator.
- Sits between the sample buffer (valid/ready in) and the bin output collector (valid/ready out).

Parameters:
- PAIRS, 8: number of sample pairs; the block takes 2*PAIRS samples. Power of two, at least 2.
- DATA_W, 16: sample width, two's complement.
- COEF_W, 32: coefficient and offset width, signed fixed-point; the binary point is opaque to this block.
- OUT_W, 32: output width.
- ACC_W (localparam), COEF_W+DATA_W+$clog2(PAIRS)+1: accumulator width.
- AW (localparam), $clog2(PAIRS)+1: coefficient address width.

Ports:
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- coef_we, in, 1: coefficient table write strobe.
- coef_addr, in, AW: bit0 = select value (0/1); bits AW-1:1 = pair index k.
- coef_wdata, in, COEF_W: coefficient value.
- off_we, in, 1: offset register write strobe.
- off_wdata, in, COEF_W: OBC offset constant, sign-extended into the accumulator.
- in_valid, in, 1: sample vector valid.
- in_ready, out, 1: engine can accept a vector.
- in_data, in, 2*PAIRS*DATA_W: sample x_i occupies bits [i*DATA_W +: DATA_W].
- out_valid, out, 1: result valid.
- out_ready, in, 1: downstream accepts the result.
- out_data, out, OUT_W: result.
- sat_flag, out, 1: result was clamped; qualified by out_valid.
- busy, out, 1: high in RUN and DONE.

Behaviour:
- Reset (async assert, sync deassert):
  - FSM goes to IDLE; the table and offset clear to 0.
  - Accumulator, shift registers and cycle counter clear.
  - Reset values: out_valid=0, out_data=0, sat_flag=0, in_ready=1, busy=0.
  - A reset asserted during RUN or DONE aborts the job; no result is produced.
- Table and offset writes:
  - Accepted only in IDLE; ignored in RUN and DONE.
  - A write in the same cycle as an accepted in_valid takes effect and is used by that job.
- Function:
  - sel_k,j = x_{2k}[j] XOR x_{2k+1}[j].
  - P_j = sum over k of C[k][sel_k,j], computed in ACC_W bits.
  - result = sext(offset) + sum over j<DATA_W-1 of (P_j << j) - (P_{DATA_W-1} << (DATA_W-1)).
  - The result is exact in ACC_W bits.
- IDLE:
  - in_ready=1.
  - On in_valid: capture in_data, set acc <= sext(offset), cnt <= 0, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle: acc += P_cnt<<cnt, except acc -= P_cnt<<cnt when cnt==DATA_W-1; then cnt++.
  - Once the MSB cycle is done (cnt==DATA_W-1), register out_data and sat_flag, set out_valid=1, go to DONE.
- DONE:
  - out_data and sat_flag are held stable while out_ready=0.
  - On out_ready: out_valid=0, go to IDLE.
  - in_valid is ignored in RUN and DONE.
- Timing:
  - Latency: out_valid rises DATA_W cycles after the accept edge.
  - Minimum initiation interval: DATA_W+2 cycles with out_ready held high.
- Boundary: in_data all zeros still runs the full DATA_W cycles, because the all-zero selects index C[k][0].

Optional Feature:
- Macro: OBC_OUT_SAT_EN.
- Defined: if acc lies outside the signed OUT_W range, out_data is clamped to 2^(OUT_W-1)-1 or -2^(OUT_W-1) and sat_flag=1.
- Undefined: out_data = acc[OUT_W-1:0] (wrap) and sat_flag is tied to 0.

Test Plan:
All scenarios use default parameters.
1. Reset, offset=5, table all 0, any in_data -> out_data=5; out_valid rises 16 cycles after accept.
2. C[0][1]=1, rest 0, offset 0; x0=0x0001, all other samples 0 -> out_data=1.
3. Same table; x0=0x8000, others 0 -> out_data=-32768 (0xFFFF8000).
4. C[0][0]=3, rest 0; x0=x1=0xFFFF, others 0 -> 3*(2^15-1)-3*2^15 = -3 (0xFFFFFFFD).
5. Hold out_ready=0 for 10 cycles in DONE while pulsing in_valid and coef_we -> out_data stable, in_ready=0, table unchanged. Then out_ready=1 -> IDLE next cycle. Separately, assert rst_n=0 mid-RUN -> immediate IDLE, out_valid=0, table zeroed.
6. All 16 entries 0x7FFFFFFF, offset 0, in_data all 0 -> acc = -8*(2^31-1). With OBC_OUT_SAT_EN: out_data=0x80000000, sat_flag=1. Without it: out_data=0x00000008, sat_flag=0.
